burst_xfer_engine: RTL and testbench

BURST_XFER_ENGINE -- requirements
Module: burst_xfer_engine

---
 rtl/burst_xfer_engine.sv | 184 ++++++++++++++++++
 tb/tb_burst_xfer_engine.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_xfer_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | burst_xfer_engine                                                        |
// | Moves beats between a register bank and a burst stream in either way.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module burst_xfer_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_rw,
  input  logic [LEN_W-1:0]  cfg_length,
  input  logic [LEN_W-1:0]  cfg_max_burst,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic              abort,
  output logic              rb_req,
  output logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_wdata,
  input  logic [DATA_W-1:0] rb_rdata,
  input  logic              rb_ack,
  output logic              idle,
  output logic              done,
  output logic              err,
  output logic              bo_valid,
  output logic [DATA_W-1:0] bo_data,
  output logic              bo_last,
  input  logic              bo_ready,
  input  logic              bi_valid,
  input  logic [DATA_W-1:0] bi_data,
  input  logic              bi_last,
  output logic              bi_ready
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CFG      = 3'd1,
    WR_FETCH = 3'd2,
    WR_SEND  = 3'd3,
    RD_WAIT  = 3'd4,
    RD_STORE = 3'd5,
    DONE     = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  maxb_q, maxb_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] bo_data_q, bo_data_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_w;
  logic              final_w;

  // maxb_q is never 0 (normalised when latched), so maxb_q-1 cannot underflow
  assign last_w  = (beat_q == (maxb_q - LEN_W'(1))) || (rem_q == LEN_W'(1));
  assign final_w = (rem_q == LEN_W'(1));

  assign idle     = (state_q == IDLE);
  assign err      = err_q;
  assign rb_addr  = addr_q;
  assign rb_wdata = wdata_q;
  assign bo_data  = bo_data_q;
  assign bo_last  = (state_q == WR_SEND) && last_w;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    maxb_d    = maxb_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    err_d     = err_q;
    bo_data_d = bo_data_q;
    wdata_d   = wdata_q;
    rb_req    = 1'b0;
    bo_valid  = 1'b0;
    bi_ready  = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d = CFG;
          rem_d   = cfg_length;
          maxb_d  = (cfg_max_burst == '0) ? LEN_W'(1) : cfg_max_burst;
          addr_d  = cfg_base_addr;
          rw_d    = cfg_rw;
        end
      end
      CFG: begin
        err_d  = 1'b0;
        beat_d = '0;
        if (rem_q == '0)  state_d = DONE;
        else if (rw_q)    state_d = WR_FETCH;
        else              state_d = RD_WAIT;
      end
      WR_FETCH: begin
        rb_req = 1'b1;
        if (rb_ack) begin
          bo_data_d = rb_rdata;
          state_d   = WR_SEND;
        end
      end
      WR_SEND: begin
        bo_valid = 1'b1;
        if (bo_ready) begin
          rem_d   = rem_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          beat_d  = last_w ? '0 : beat_q + LEN_W'(1);
          state_d = final_w ? DONE : WR_FETCH;
        end
      end
      RD_WAIT: begin
        bi_ready = 1'b1;
        if (bi_valid) begin
          wdata_d = bi_data;
          if (bi_last != last_w) err_d = 1'b1;
          state_d = RD_STORE;
        end
      end
      RD_STORE: begin
        rb_req = 1'b1;
        if (rb_ack) begin
          rem_d   = rem_q - LEN_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          beat_d  = last_w ? '0 : beat_q + LEN_W'(1);
          state_d = final_w ? DONE : RD_WAIT;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every handshake decided above in the same cycle
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      err_d     = 1'b1;
      rem_d     = rem_q;
      beat_d    = beat_q;
      addr_d    = addr_q;
      bo_data_d = bo_data_q;
      wdata_d   = wdata_q;
      rb_req    = 1'b0;
      bo_valid  = 1'b0;
      bi_ready  = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      maxb_q    <= '0;
      beat_q    <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      err_q     <= 1'b0;
      bo_data_q <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      maxb_q    <= maxb_d;
      beat_q    <= beat_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      err_q     <= err_d;
      bo_data_q <= bo_data_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_burst_xfer_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_burst_xfer_engine                                                     |
// | Directed and randomized transfers against a queue-based reference model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_burst_xfer_engine;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int LW = 8;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start, cfg_rw, abort;
  logic [LW-1:0] cfg_length, cfg_max_burst;
  logic [AW-1:0] cfg_base_addr;
  logic          rb_req, rb_ack;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] rb_wdata, rb_rdata;
  logic          idle, done, err;
  logic          bo_valid, bo_last, bo_ready;
  logic [DW-1:0] bo_data;
  logic          bi_valid, bi_last, bi_ready;
  logic [DW-1:0] bi_data;

  always #5 clk = ~clk;

  burst_xfer_engine #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_rw(cfg_rw),
    .cfg_length(cfg_length), .cfg_max_burst(cfg_max_burst),
    .cfg_base_addr(cfg_base_addr), .abort(abort),
    .rb_req(rb_req), .rb_addr(rb_addr), .rb_wdata(rb_wdata),
    .rb_rdata(rb_rdata), .rb_ack(rb_ack),
    .idle(idle), .done(done), .err(err),
    .bo_valid(bo_valid), .bo_data(bo_data), .bo_last(bo_last), .bo_ready(bo_ready),
    .bi_valid(bi_valid), .bi_data(bi_data), .bi_last(bi_last), .bi_ready(bi_ready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem [DEPTH];
  bit            mode_rw;
  int            ack_lat, rb_wait;
  int            stall_beat, stall_left;
  bit            held, held_l;
  logic [DW-1:0] held_d;
  int            done_cnt, req_seen, bov_seen, bir_seen;
  bit            idle_s, req_s;
  int            fetch_addr[$], wr_addr[$];
  logic [DW-1:0] bo_d[$], wr_data[$], src_d[$], sent_d[$];
  bit            bo_l[$], src_l[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_last(int i, int len, int mb);
    int m = (mb == 0) ? 1 : mb;
    return ((i % m) == m - 1) || (i == len - 1);
  endfunction

  // One clock: apply abort, sample outputs, drive RB/sink/source responses
  task automatic step(input bit ab);
    abort = ab;
    #2;
    idle_s = idle;
    req_s  = rb_req;
    if (done)     done_cnt++;
    if (rb_req)   req_seen++;
    if (bo_valid) bov_seen++;
    if (bi_ready) bir_seen++;

    if (rb_req) begin
      if (rb_wait >= ack_lat) begin
        rb_ack   = 1'b1;
        rb_rdata = mem[rb_addr];
        rb_wait  = 0;
        if (mode_rw) fetch_addr.push_back(int'(rb_addr));
        else begin
          wr_addr.push_back(int'(rb_addr));
          wr_data.push_back(rb_wdata);
          mem[rb_addr] = rb_wdata;
        end
      end else begin
        rb_ack = 1'b0;
        rb_wait++;
      end
    end else begin
      rb_ack   = 1'($urandom_range(0, 1));
      rb_rdata = DW'($urandom);
      rb_wait  = 0;
    end

    if (held) begin
      check("hold_valid", 32'(bo_valid), 32'd1);
      check("hold_data", 32'(bo_data), 32'(held_d));
      check("hold_last", 32'(bo_last), 32'(held_l));
    end
    bo_ready = 1'b1;
    if (bo_valid && bo_d.size() == stall_beat && stall_left > 0) begin
      bo_ready = 1'b0;
      stall_left--;
    end
    held   = bo_valid && !bo_ready;
    held_d = bo_data;
    held_l = bo_last;
    if (bo_valid && bo_ready) begin
      bo_d.push_back(bo_data);
      bo_l.push_back(bo_last);
    end

    if (src_d.size() > 0) begin
      bi_valid = 1'b1;
      bi_data  = src_d[0];
      bi_last  = src_l[0];
      if (bi_ready) begin
        void'(src_d.pop_front());
        void'(src_l.pop_front());
      end
    end else begin
      bi_valid = 1'b0;
      bi_data  = DW'($urandom);
      bi_last  = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input bit rw, input int len, input int mb, input int base);
    mode_rw = rw;
    fetch_addr.delete(); wr_addr.delete(); bo_d.delete(); bo_l.delete(); wr_data.delete();
    done_cnt = 0; req_seen = 0; bov_seen = 0; bir_seen = 0;
    rb_wait = 0; held = 0;
    cfg_rw = rw; cfg_length = LW'(len); cfg_max_burst = LW'(mb);
    cfg_base_addr = AW'(base); cfg_start = 1'b1;
    step(0);
    cfg_start = 1'b0;
    step(0);
    cfg_rw = 1'($urandom); cfg_length = LW'($urandom);
    cfg_max_burst = LW'($urandom); cfg_base_addr = AW'($urandom);
  endtask

  task automatic run_to_idle(input int budget);
    int k = 0;
    idle_s = 0;
    while (!idle_s && k < budget) begin
      step(0);
      k++;
    end
    if (!idle_s) check("timeout_idle", 32'd0, 32'd1);
  endtask

  task automatic load_source(input int len, input int mb, input int flip_at, output bit exp_err);
    exp_err = 0;
    src_d.delete(); src_l.delete(); sent_d.delete();
    for (int i = 0; i < len; i++) begin
      logic [DW-1:0] d = DW'($urandom);
      bit l = exp_last(i, len, mb);
      if (i == flip_at || (flip_at < -1 && $urandom_range(0, 5) == 0)) begin
        l = !l;
        exp_err = 1;
      end
      src_d.push_back(d); src_l.push_back(l); sent_d.push_back(d);
    end
  endtask

  task automatic check_write(input string tg, input int len, input int mb, input int base);
    check({tg, "_beats"}, 32'(bo_d.size()), 32'(len));
    check({tg, "_fetches"}, 32'(fetch_addr.size()), 32'(len));
    check({tg, "_req_cycles"}, 32'(req_seen), 32'(len * (ack_lat + 1)));
    check({tg, "_done"}, 32'(done_cnt), 32'd1);
    check({tg, "_err"}, 32'(err), 32'd0);
    for (int i = 0; i < len && i < bo_d.size() && i < fetch_addr.size(); i++) begin
      int a = (base + i) % DEPTH;
      check({tg, "_addr"}, 32'(fetch_addr[i]), 32'(a));
      check({tg, "_data"}, 32'(bo_d[i]), 32'(mem[a]));
      check({tg, "_last"}, 32'(bo_l[i]), 32'(exp_last(i, len, mb)));
    end
  endtask

  task automatic check_read(input string tg, input int len, input int base, input bit exp_err);
    check({tg, "_stores"}, 32'(wr_addr.size()), 32'(len));
    check({tg, "_done"}, 32'(done_cnt), 32'd1);
    check({tg, "_err"}, 32'(err), 32'(exp_err));
    check({tg, "_no_bo"}, 32'(bov_seen), 32'd0);
    for (int i = 0; i < len && i < wr_addr.size(); i++) begin
      check({tg, "_waddr"}, 32'(wr_addr[i]), 32'((base + i) % DEPTH));
      check({tg, "_wdata"}, 32'(wr_data[i]), 32'(sent_d[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tg);
    check({tg, "_idle"}, 32'(idle), 32'd1);
    check({tg, "_rb_req"}, 32'(rb_req), 32'd0);
    check({tg, "_done"}, 32'(done), 32'd0);
    check({tg, "_err"}, 32'(err), 32'd0);
    check({tg, "_bo_valid"}, 32'(bo_valid), 32'd0);
    check({tg, "_bo_last"}, 32'(bo_last), 32'd0);
    check({tg, "_bi_ready"}, 32'(bi_ready), 32'd0);
    check({tg, "_rb_addr"}, 32'(rb_addr), 32'd0);
    check({tg, "_rb_wdata"}, 32'(rb_wdata), 32'd0);
    check({tg, "_bo_data"}, 32'(bo_data), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit e;
    int len, mb, base;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    rst = 1'b1; cfg_start = 0; cfg_rw = 0; cfg_length = '0; cfg_max_burst = '0;
    cfg_base_addr = '0; abort = 0; rb_ack = 0; rb_rdata = '0; bo_ready = 1;
    bi_valid = 0; bi_data = '0; bi_last = 0;
    ack_lat = 1; stall_beat = -1; stall_left = 0; held = 0;
    step(0); step(0);
    check_reset_outputs("por");
    rst = 1'b0;

    // Write across the address wrap, bursts of two
    start_xfer(1, 5, 2, 'h1FE);
    run_to_idle(60);
    check_write("wr_wrap", 5, 2, 'h1FE);

    // Read with correct last framing
    load_source(3, 4, -1, e);
    start_xfer(0, 3, 4, 'h010);
    run_to_idle(60);
    check_read("rd_ok", 3, 'h010, e);

    // Sink back-pressure on the first beat
    stall_beat = 0; stall_left = 3;
    start_xfer(1, 2, 0, 'h020);
    run_to_idle(60);
    check_write("wr_stall", 2, 0, 'h020);
    check("wr_stall_used", 32'(stall_left), 32'd0);
    stall_beat = -1;

    // Zero-length transfer
    start_xfer(0, 0, 3, 'h030);
    run_to_idle(20);
    check("len0_done", 32'(done_cnt), 32'd1);
    check("len0_req", 32'(req_seen), 32'd0);
    check("len0_bo", 32'(bov_seen), 32'd0);
    check("len0_bi", 32'(bir_seen), 32'd0);

    // Early bi_last raises err but all beats are stored
    load_source(3, 4, 0, e);
    start_xfer(0, 3, 4, 'h040);
    run_to_idle(60);
    check_read("rd_badlast", 3, 'h040, e);

    // Randomized mix of writes and reads
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(1, 12);
      mb = $urandom_range(0, 5);
      base = $urandom_range(0, DEPTH - 1);
      ack_lat = $urandom_range(0, 2);
      if (t % 2 == 0) begin
        start_xfer(1, len, mb, base);
        run_to_idle(200);
        check_write("rnd_wr", len, mb, base);
      end else begin
        load_source(len, mb, -2, e);
        start_xfer(0, len, mb, base);
        run_to_idle(200);
        check_read("rnd_rd", len, base, e);
      end
    end

    // Abort while a store is pending
    ack_lat = 3;
    load_source(3, 4, -1, e);
    start_xfer(0, 3, 4, 'h050);
    begin
      int k = 0;
      req_s = 0;
      while (!req_s && k < 20) begin step(0); k++; end
      check("abort_reached_store", 32'(req_s), 32'd1);
    end
    step(1);
    check("abort_req_dropped", 32'(req_s), 32'd0);
    step(0);
    check("abort_idle", 32'(idle_s), 32'd1);
    check("abort_err", 32'(err), 32'd1);
    check("abort_no_store", 32'(wr_addr.size()), 32'd0);
    step(0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    src_d.delete(); src_l.delete();

    // Reset in the middle of a write
    ack_lat = 1;
    start_xfer(1, 4, 2, 'h060);
    step(0); step(0); step(0);
    rst = 1'b1;
    step(0);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    step(0); step(0);
    check("rst_mid_no_done", 32'(done_cnt), 32'd0);
    check("rst_mid_idle", 32'(idle_s), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
